ram_bus_master: RTL
===================

// Module: ram_bus_master
// PURPOSE
//   Upstream sequencer for the ram block. Converts single-beat CPU-side
//   requests into ram's two-phase shared-bus protocol:
//   - address phase first;
//   - data phase second, driven by the master for a write and by ram for a read.
//   Owns the enable, rw and bus-drive timing, and returns one response per request.
// PARAMETERS
//   WIDTH     8  bus/address/data width; matches ram's 8-bit bus
//   READ_LAT  1  data-phase cycles before read data is sampled; legal 1..4
// PORTS
//   clock       in     1      system clock; all state changes on posedge
//   n_reset     in     1      asynchronous, active-low reset
//   req_valid   in     1      request present
//   req_ready   out    1      master can accept a request this cycle
//   req_write   in     1      1 = write, 0 = read
//   req_addr    in     WIDTH  target address
//   req_wdata   in     WIDTH  write data; ignored for reads
//   resp_valid  out    1      one-cycle pulse: request finished
//   resp_rdata  out    WIDTH  read data; valid with resp_valid on reads
//   enable      out    1      to ram.enable
//   rw          out    1      to ram.rw; 1 = write, 0 = read
//   bus         inout  WIDTH  shared ram bus; master drives it only as stated below
// BEHAVIOUR
//   Reset (n_reset low, effective immediately, no clock needed):
//   - state=IDLE; enable=0; rw=0; bus=Z; resp_valid=0; resp_rdata=0;
//     req_ready=1; read-wait counter=0.
//   Handshake:
//   - A request is accepted on a posedge where req_valid && req_ready.
//   - req_addr, req_wdata and req_write are captured at that edge.
//   - req_ready=1 only in IDLE. It is a registered state decode and does not
//     depend on req_valid.
//   - No back-pressure on responses. resp_valid is high for exactly 1 cycle.
//   State machine (one state per cycle unless noted):
//   - IDLE
//     - enable=0, bus=Z.
//     - On accept -> ADDR.
//   - ADDR
//     - enable=1, rw=captured write bit, bus=captured addr.
//     - Next state: DATA_W if write, else DATA_R.
//   - DATA_W
//     - enable=1, rw=1, bus=captured wdata.
//     - Next state: IDLE, and set resp_valid for the following cycle.
//   - DATA_R
//     - enable=1, rw=0, bus=Z.
//     - Stays READ_LAT cycles, counted by a counter that increments and resets
//       to 0 on exit.
//     - On the posedge ending the last DATA_R cycle: resp_rdata<=bus, then IDLE
//       with resp_valid=1.
//   Latency, with the accept edge at cycle 0:
//   - Write: resp_valid is high in cycle 3.
//   - Read: resp_valid is high in cycle 2+READ_LAT.
//   - The cycle in which resp_valid is high is IDLE, with req_ready=1.
//     A new request may be accepted in that same cycle.
//   Throughput:
//   - Write: one per 3 cycles.
//   - Read: one per 2+READ_LAT cycles.
//   Bus ownership:
//   - The master drives bus only in ADDR and DATA_W; bus=Z in every other
//     state and during reset.
//   - Never drive bus in the cycle immediately after DATA_R. IDLE guarantees
//     this turnaround.
//   resp_rdata:
//   - Holds its last value between reads.
//   - Unchanged by writes.
//   Reset mid-operation:
//   - Aborts the transfer with no resp_valid.
//   - enable drops to 0 and bus goes to Z asynchronously.
//   - A partially issued write may leave ram unchanged; the caller must re-issue.
//   Request signals changing after acceptance have no effect.
//   req_valid while not ready is held off. The caller must keep it asserted.
// TESTING (bench instantiates ram_bus_master + ram sharing bus; T=2ns)
//   1. Reset, then write addr=10 data=15.
//      -> enable=1 for exactly 2 cycles; bus=10, then 15; resp_valid in cycle 3;
//         ram memory[10]==15.
//   2. After 1, read addr=10 (READ_LAT=1).
//      -> bus=Z in DATA_R; resp_valid in cycle 3; resp_rdata==15.
//   3. Back-to-back: write 0x20<-0xA5, write 0x21<-0x5A, read 0x20, read 0x21,
//      with req_valid held high.
//      -> accepts every 3 cycles; reads return 0xA5 then 0x5A.
//   4. req_valid held high while busy.
//      -> req_ready=0 outside IDLE; no second accept until the resp_valid cycle;
//         req_addr changed mid-op does not alter bus.
//   5. Assert n_reset=0 during DATA_W of write 0x30<-0x77.
//      -> enable=0 and bus=Z with no clock edge; state IDLE; no resp_valid;
//         req_ready=1.
//   6. READ_LAT=3: write 0x05<-0x3C, then read 0x05.
//      -> enable=1 for 4 cycles on the read; resp_valid in cycle 5; rdata=0x3C.

Source files
------------

// File: rtl/ram_bus_master.sv
// Sequences single-beat CPU requests into ram's two-phase (address, then data) shared-bus protocol.
// Latency: write response 3 cycles after accept, read response 2+READ_LAT cycles after accept.
// Backpressure: req_ready only in IDLE; responses are a one-cycle pulse with no backpressure.
module ram_bus_master #(
  parameter int WIDTH    = 8,
  parameter int READ_LAT = 1
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             enable,
  output logic             rw,
  inout  wire  [WIDTH-1:0] bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    DATA_W = 2'd2,
    DATA_R = 2'd3
  } state_t;

  localparam logic [2:0] LAST_RD = 3'(READ_LAT - 1);

  state_t           state;
  logic [2:0]       lat_cnt;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] drive_q;
  logic             drive_en;

  // The drive enable is a flop, so reset releases the bus without waiting for a clock.
  assign bus = drive_en ? drive_q : {WIDTH{1'bz}};

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      enable     <= 1'b0;
      rw         <= 1'b0;
      drive_en   <= 1'b0;
      drive_q    <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      req_ready  <= 1'b1;
      lat_cnt    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= ADDR;
            req_ready <= 1'b0;
            enable    <= 1'b1;
            rw        <= req_write;
            wdata_q   <= req_wdata;
            drive_en  <= 1'b1;
            drive_q   <= req_addr;
          end
        end
        ADDR: begin
          if (rw) begin
            state   <= DATA_W;
            drive_q <= wdata_q;
          end else begin
            // Hand the bus to ram for the read data phase.
            state    <= DATA_R;
            drive_en <= 1'b0;
            lat_cnt  <= '0;
          end
        end
        DATA_W: begin
          state      <= IDLE;
          enable     <= 1'b0;
          rw         <= 1'b0;
          drive_en   <= 1'b0;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
        end
        DATA_R: begin
          if (lat_cnt == LAST_RD) begin
            resp_rdata <= bus;
            lat_cnt    <= '0;
            state      <= IDLE;
            enable     <= 1'b0;
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: begin
          state     <= IDLE;
          enable    <= 1'b0;
          rw        <= 1'b0;
          drive_en  <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
